// File: rtl/press_event_decoder.sv
// Turns the debounced button level into one-enabled-cycle click, double-click
// and long-press events. All timing is counted in clk_en-qualified cycles.
module press_event_decoder #(
  parameter int LONG_PRESS_CYCLES          = 8,
  parameter int DOUBLE_CLICK_WINDOW_CYCLES = 5
) (
  input  logic       clk,
  input  logic       async_rst_n,
  input  logic       clk_en,
  input  logic       debounced_level,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press_start,
  output logic       long_press_release,
  output logic [2:0] fsm_state
);

  localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > DOUBLE_CLICK_WINDOW_CYCLES) ?
                              LONG_PRESS_CYCLES : DOUBLE_CLICK_WINDOW_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Last counter value of each timed phase: comparing against N-1 is cnt+1==N
  // without needing a wider adder.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_CLICK_WINDOW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS1       = 3'd1,
    GAP          = 3'd2,
    LONG         = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             single_nxt, double_nxt, lstart_nxt, lrel_nxt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    lstart_nxt = 1'b0;
    lrel_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (debounced_level) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (!debounced_level) begin
          state_nxt = GAP;
        end else if (cnt == LONG_LAST) begin
          state_nxt  = LONG;
          lstart_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        // Level wins over the timeout, so a rise on the last window sample
        // still counts as a double click.
        if (debounced_level) begin
          state_nxt  = WAIT_RELEASE;
          double_nxt = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nxt  = IDLE;
          single_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (!debounced_level) begin
          state_nxt = IDLE;
          lrel_nxt  = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!debounced_level) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_RELEASE;
    endcase

    if (state_nxt != state) cnt_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state              <= WAIT_RELEASE;
      cnt                <= '0;
      single_click       <= 1'b0;
      double_click       <= 1'b0;
      long_press_start   <= 1'b0;
      long_press_release <= 1'b0;
    end else if (clk_en) begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      single_click       <= single_nxt;
      double_click       <= double_nxt;
      long_press_start   <= lstart_nxt;
      long_press_release <= lrel_nxt;
    end
  end

  assign fsm_state = state;

endmodule
